// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types, sizes and the round-robin search helper for the 8-way arbiter.
package mux8_rr_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Rotate the request vector so 'start' lands at bit 0, then take the
    // lowest set bit; the winner index is mapped back by adding 'start'.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   start);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        pick_t                p;
        dbl     = {req, req};
        rot     = dbl[start +: NUM_REQ];
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                p.found = 1'b1;
                p.idx   = start + SEL_W'(i);
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_sel.sv
// Output data mux: forwards the current owner's data bit, forced low with no owner.
module mux8_sel
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] DATA_IN,
    input  logic [SEL_W-1:0]   SEL,
    input  logic               VALID,
    output logic               Z
);

    assign Z = VALID & DATA_IN[SEL];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// 8-requester round-robin arbiter with bounded hold time and a gated data mux.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int HOLD_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] DATA_IN,
    output logic [SEL_W-1:0]   SEL,
    output logic [NUM_REQ-1:0] GNT,
    output logic               VALID,
    output logic               Z
);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q,   sel_d;
    logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
    logic                 valid_q, valid_d;
    logic [SEL_W-1:0]     ptr_q,   ptr_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    logic [NUM_REQ-1:0]   others;
    logic [SEL_W-1:0]     sel_next;
    logic                 keep;
    pick_t                pick_idle;
    pick_t                pick_rel;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_LIMIT);

    // The current owner is masked out so a releasing requester cannot win the
    // immediate regrant; the release search starts just past the owner.
    assign others    = REQ & ~gnt_q;
    assign sel_next  = sel_q + SEL_W'(1);
    assign keep      = REQ[sel_q] && ((cnt_q < HOLD_LIM) || (others == '0));
    assign pick_idle = rr_pick(REQ, ptr_q);
    assign pick_rel  = rr_pick(others, sel_next);

    // Next-state and next-output decision for the IDLE/GRANT controller.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    sel_d   = pick_idle.idx;
                    gnt_d   = onehot(pick_idle.idx);
                    valid_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = GRANT;
                end else begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (keep) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    ptr_d = sel_next;
                    if (pick_rel.found) begin
                        sel_d   = pick_rel.idx;
                        gnt_d   = onehot(pick_rel.idx);
                        valid_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over any pending transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign SEL   = sel_q;
    assign GNT   = gnt_q;
    assign VALID = valid_q;

    mux8_sel u_sel (
        .DATA_IN (DATA_IN),
        .SEL     (sel_q),
        .VALID   (valid_q),
        .Z       (Z)
    );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter (HOLD_LIMIT = 4).
module tb_mux8_rr_arbiter;

    logic       CLK;
    logic       RST;
    logic [7:0] REQ;
    logic [7:0] DATA_IN;
    logic [2:0] SEL;
    logic [7:0] GNT;
    logic       VALID;
    logic       Z;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] din;
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       v;
        logic       z;
    } vec_t;

    vec_t tbl[$];

    mux8_rr_arbiter #(.HOLD_LIMIT(4)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .DATA_IN (DATA_IN),
        .SEL     (SEL),
        .GNT     (GNT),
        .VALID   (VALID),
        .Z       (Z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [7:0] req, input logic [7:0] din);
        RST     = rst;
        REQ     = req;
        DATA_IN = din;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] s, input logic [7:0] g,
                           input logic v, input logic z);
        chk({tag, ".sel"},   32'(SEL),   32'(s));
        chk({tag, ".gnt"},   32'(GNT),   32'(g));
        chk({tag, ".valid"}, 32'(VALID), 32'(v));
        chk({tag, ".z"},     32'(Z),     32'(z));
    endtask

    function automatic void add(input logic rst, input logic [7:0] req, input logic [7:0] din,
                                input logic [2:0] s, input logic [7:0] g, input logic v,
                                input logic z);
        vec_t e;
        e.rst = rst; e.req = req; e.din = din;
        e.sel = s;   e.gnt = g;   e.v = v; e.z = z;
        tbl.push_back(e);
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        RST     = 1'b1;
        REQ     = 8'h00;
        DATA_IN = 8'h00;

        // reset with all requesting, then first grant goes to 0
        add(1, 8'hFF, 8'h00, 3'd0, 8'h00, 0, 0);
        add(1, 8'hFF, 8'h00, 3'd0, 8'h00, 0, 0);
        add(0, 8'hFF, 8'h01, 3'd0, 8'h01, 1, 1);
        add(0, 8'h00, 8'h01, 3'd0, 8'h00, 0, 0);
        // sole requester 5 held for 10 cycles past the hold limit
        for (int i = 0; i < 10; i++)
            add(0, 8'h20, (i == 2) ? 8'h00 : 8'h20, 3'd5, 8'h20, 1, (i == 2) ? 1'b0 : 1'b1);
        add(0, 8'h00, 8'hFF, 3'd5, 8'h00, 0, 0);
        // wrap-around from owner 7 to owner 0
        add(0, 8'h80, 8'h80, 3'd7, 8'h80, 1, 1);
        add(0, 8'h81, 8'h80, 3'd7, 8'h80, 1, 1);
        add(0, 8'h01, 8'h01, 3'd0, 8'h01, 1, 1);
        add(0, 8'h00, 8'h01, 3'd0, 8'h00, 0, 0);
        // data path with owner 3
        add(0, 8'h08, 8'h08, 3'd3, 8'h08, 1, 1);
        add(0, 8'h08, 8'hF7, 3'd3, 8'h08, 1, 0);
        add(0, 8'h08, 8'h08, 3'd3, 8'h08, 1, 1);
        add(0, 8'h00, 8'hFF, 3'd3, 8'h00, 0, 0);
        add(0, 8'h00, 8'hFF, 3'd3, 8'h00, 0, 0);
        // contended hold limit: 4 owns 4 cycles, then hands to 3 with no gap
        add(0, 8'h18, 8'h00, 3'd4, 8'h10, 1, 0);
        add(0, 8'h18, 8'h00, 3'd4, 8'h10, 1, 0);
        add(0, 8'h18, 8'h00, 3'd4, 8'h10, 1, 0);
        add(0, 8'h18, 8'h00, 3'd4, 8'h10, 1, 0);
        add(0, 8'h18, 8'h08, 3'd3, 8'h08, 1, 1);
        add(0, 8'h18, 8'h08, 3'd3, 8'h08, 1, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].din);
            chk_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].v, tbl[i].z);
        end

        // fairness: constant full request, each owner held exactly 4 cycles
        step(1, 8'hFF, 8'h00);
        for (int c = 0; c < 33; c++) begin
            logic [2:0] own;
            own = 3'((c / 4) % 8);
            step(0, 8'hFF, 8'h00);
            chk($sformatf("fair%0d.sel", c), 32'(SEL), 32'(own));
            chk($sformatf("fair%0d.gnt", c), 32'(GNT), 32'(8'h01 << own));
        end

        // mid-grant reset: owner 4 at hold count 2 loses grant at the reset edge
        step(1, 8'h00, 8'h00);
        step(0, 8'h01, 8'h00);
        chk_out("mg.own0", 3'd0, 8'h01, 1, 0);
        step(0, 8'h10, 8'h10);
        chk_out("mg.own4a", 3'd4, 8'h10, 1, 1);
        step(0, 8'h10, 8'h10);
        chk_out("mg.own4b", 3'd4, 8'h10, 1, 1);
        step(1, 8'h10, 8'h10);
        chk_out("mg.rst", 3'd0, 8'h00, 0, 0);
        step(0, 8'h10, 8'h10);
        chk_out("mg.regrant", 3'd4, 8'h10, 1, 1);

        // pointer is cleared by reset: search restarts at 0, not at 1
        step(1, 8'h00, 8'h00);
        step(0, 8'h01, 8'h00);
        step(0, 8'h10, 8'h00);
        chk_out("ptr.own4", 3'd4, 8'h10, 1, 0);
        step(1, 8'h11, 8'h00);
        chk_out("ptr.rst", 3'd0, 8'h00, 0, 0);
        step(0, 8'h11, 8'h01);
        chk_out("ptr.from0", 3'd0, 8'h01, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
